// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operation request/result handshake bundle for alu_exec_unit
//   in_valid/in_ready, alu_opcode, operand_a, operand_b : request channel (master -> slave)
//   out_valid/out_ready, result, flag_zero, flag_carry, err : result channel (slave -> master)
interface alu_exec_unit_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] alu_opcode;
   logic [7:0] operand_a;
   logic [7:0] operand_b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       flag_zero;
   logic       flag_carry;
   logic       err;
   modport master (
      output in_valid, alu_opcode, operand_a, operand_b, out_ready,
      input  in_ready, out_valid, result, flag_zero, flag_carry, err
   );
   modport slave (
      input  in_valid, alu_opcode, operand_a, operand_b, out_ready,
      output in_ready, out_valid, result, flag_zero, flag_carry, err
   );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: 8-bit execute stage, single-cycle ops plus an 8-iteration shift-add MUL
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : alu_exec_unit_if.slave, request in / result+flags+err out
module alu_exec_unit (
   input logic clk,
   input logic reset,
   alu_exec_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;
   state_t      state, state_nxt;
   logic [2:0]  cnt;
   logic [15:0] acc, mcand, acc_nxt;
   logic [7:0]  mplier, op_a, op_b, res_q, r;
   logic [8:0]  t;
   logic        zero_q, carry_q, err_q, c, z, e, accept, is_mul;
   assign op_a    = bus.operand_a;
   assign op_b    = bus.operand_b;
   assign is_mul  = bus.alu_opcode == 4'd10;
   assign accept  = bus.in_valid && bus.in_ready;
   assign acc_nxt = mplier[0] ? acc + mcand : acc;
   // single-cycle result; MUL is produced by the sequencer instead
   always_comb begin
      r = '0;
      c = 1'b0;
      e = 1'b0;
      t = '0;
      case (bus.alu_opcode)
         4'd0:  {c, r} = {1'b0, op_a} + {1'b0, op_b};
         4'd1:  begin r = op_a - op_b; c = op_a < op_b; end
         4'd2:  r = op_a & op_b;
         4'd3:  r = op_a | op_b;
         4'd4:  r = op_a ^ op_b;
         // a spare ninth bit catches the last bit shifted out, 0 for a zero shift
         4'd5:  begin t = {1'b0, op_a} << op_b[2:0]; {c, r} = t; end
         4'd6:  begin t = {op_a, 1'b0} >> op_b[2:0]; {r, c} = t; end
         4'd7:  begin r = op_a + 8'd1; c = op_a == 8'hff; end
         4'd8:  begin r = op_a - 8'd1; c = op_a == 8'h00; end
         4'd9:  r = ~op_a;
         4'd11: r = op_b;
         4'd12: begin r = op_a; c = op_a < op_b; end
         4'd13, 4'd14, 4'd15: e = 1'b1;
         default: r = '0;
      endcase
      z = (bus.alu_opcode == 4'd12) ? op_a == op_b : r == 8'd0;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      if (accept) state_nxt = is_mul ? MUL_BUSY : DONE;
      else if (state == MUL_BUSY && cnt == 3'd7) state_nxt = DONE;
      else if (state == DONE && bus.out_ready) state_nxt = IDLE;
   end
   always_comb begin
      bus.in_ready   = state == IDLE || (state == DONE && bus.out_ready);
      bus.out_valid  = state == DONE;
      bus.result     = res_q;
      bus.flag_zero  = zero_q;
      bus.flag_carry = carry_q;
      bus.err        = err_q;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt     <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (accept && is_mul) begin
         mcand  <= {8'd0, op_a};
         mplier <= op_b;
         acc    <= '0;
         cnt    <= '0;
      end else if (accept) begin
         res_q   <= r;
         zero_q  <= z;
         carry_q <= c;
         err_q   <= e;
      end else if (state == MUL_BUSY) begin
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 3'd1;
         if (cnt == 3'd7) begin
            res_q   <= acc_nxt[7:0];
            zero_q  <= acc_nxt[7:0] == 8'd0;
            carry_q <= |acc_nxt[15:8];
            err_q   <= 1'b0;
         end
      end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute stage that sits directly downstream of the ISA-to-ALU opcode decoder. It accepts a 4-bit ALU opcode and two 8-bit operands through a valid/ready handshake and computes the result and flags. It presents them on an output valid/ready handshake. Most operations complete in one cycle; MUL uses an 8-iteration shift-add sequencer.

## Interface
- No parameters; data width is fixed at 8 bits and opcode width at 4 bits.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  the upstream opcode and operands are valid.
- in_ready  output  1  the unit accepts a new operation this cycle.
- alu_opcode  input  4  operation code from the decoder.
- operand_a  input  8  first operand.
- operand_b  input  8  second operand.
- out_valid  output  1  result, flags and err are valid.
- out_ready  input  1  downstream consumes the result this cycle.
- result  output  8  operation result.
- flag_zero  output  1  result == 0, except for CMP (see below).
- flag_carry  output  1  carry/borrow/overflow indication.
- err  output  1  the opcode was illegal (13–15).

## Operation
- Accept: an operation is accepted when in_valid && in_ready at a rising edge. alu_opcode, operand_a and operand_b are captured at that edge.
- Opcodes:
  - 0 ADD: a+b; carry = bit 8.
  - 1 SUB: a−b; carry = borrow (a<b).
  - 2 AND, 3 OR, 4 XOR: carry = 0.
  - 5 SHL: a<<b[2:0]; carry = last bit shifted out, 0 when shift = 0.
  - 6 SHR: logical a>>b[2:0]; carry = last bit shifted out, 0 when shift = 0.
  - 7 INC: a+1; carry = (a==FF).
  - 8 DEC: a−1; carry = (a==00).
  - 9 NOT: ~a; carry = 0.
  - 10 MUL: low byte of a*b; carry = (high byte != 0).
  - 11 PASS: result = b; carry = 0.
  - 12 CMP: result = a; flag_zero = (a==b); carry = (a<b).
  - 13–15: result = 00, flag_zero = 1, carry = 0, err = 1.
- For all opcodes except 13–15, err = 0.
- All arithmetic is modulo 256.
- FSM states:
  - IDLE: in_ready = 1, out_valid = 0.
  - MUL_BUSY: in_ready = 0, out_valid = 0; a 3-bit iteration counter runs 0..7.
  - DONE: out_valid = 1; outputs are held stable until out_ready.
- Transitions:
  - IDLE → DONE on accept of a non-MUL opcode.
  - IDLE → MUL_BUSY on accept of MUL.
  - MUL_BUSY → DONE after the 8th iteration (counter = 7).
  - DONE with out_ready and no new accept → IDLE.
  - DONE with out_ready and a new accept → DONE (non-MUL) or MUL_BUSY (MUL).
- in_ready = (state==IDLE) || (state==DONE && out_ready). This combinational path from out_ready to in_ready is required.
- MUL iteration: the multiplicand is a zero-extended to 16 bits. Each iteration adds the shifted multiplicand to a 16-bit accumulator if the current multiplier LSB is 1, then shifts the multiplicand left and the multiplier right.
- In DONE without out_ready, result, flags and err do not change, and operand inputs are ignored.

## Timing
- Reset values (asynchronous, immediate): state = IDLE, in_ready = 1, out_valid = 0, result = 00, flag_zero = 0, flag_carry = 0, err = 0, counter = 0, accumulator = 0.
- Single-cycle ops: accept at edge N → out_valid = 1 after edge N.
- MUL: accept at edge N → out_valid = 1 after edge N+8.
- Throughput: one single-cycle op per clock while out_ready stays high. MUL occupies 9 cycles from accept to result.
- Backpressure: out_valid stays high and outputs stay constant for as long as out_ready is low.
- Reset asserted mid-MUL or in DONE: the operation is discarded, with no partial result.

## Test plan
- Reset, then ADD a=F0, b=20 with out_ready=1 → one cycle later: result = 10, carry = 1, zero = 0, err = 0.
- Back-to-back with out_ready=1: SUB 05−07, then CMP 33,33, then SHL 81<<1 on consecutive cycles → three consecutive out_valid cycles:
  - result FE, carry 1;
  - result 33, zero 1, carry 0;
  - result 02, carry 1.
- MUL a=13, b=11 → in_ready low for 8 cycles; out_valid 8 cycles after accept with result 43, carry 1. Then MUL FF×00 → result 00, zero 1, carry 0.
- Hold out_ready=0 for 5 cycles after an XOR AA^FF → result stays 55 with out_valid high and in_ready low throughout; a new in_valid is not accepted until out_ready rises.
- Opcode 14 → result 00, zero 1, err 1. A following INC FF → result 00, carry 1, zero 1, err 0.
- Assert reset at iteration 4 of a MUL → out_valid 0 and in_ready 1 immediately. After reset deasserts, a DEC 00 completes with result FF, carry 1.
